uart_vip_rx_mon: RTL
====================

Name: uart_vip_rx_mon

Overview:
- Clocked, parametrised UART receive monitor for the uDMA verification IPs.
- Deserialises a UART line at a runtime-programmable baud divider and runtime frame format (5–9 data bits, none/even/odd parity, 1 or 2 stop bits).
- Buffers received characters with error flags in a FIFO drained through a valid/ready handshake.
- Pulses a line-done strobe on line feed or on reaching a programmable line length.
- Sits between the DUT's UART TX pin and bench scoreboards/loggers; replaces the free-running, unclocked receiver model.

Parameters:
- DIV_W, 16, width of the baud divider (clocks per bit).
- FIFO_DEPTH, 16, received-character buffer entries; power of two, ≥2.
- LINE_W, 8, width of the line-length counter.
- ID, 0, instance identifier, reported on id_o.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- rx_i, in, 1, asynchronous UART line from DUT; idle high.
- rx_en_i, in, 1, receiver enable.
- tx_o, out, 1, loopback: rx_i when tx_en_i else 1; combinational.
- tx_en_i, in, 1, loopback enable.
- cfg_div_i, in, DIV_W, clocks per bit; values <4 are treated as 4.
- cfg_bits_i, in, 2, data bits: 0=5, 1=6, 2=7, 3=8; ignored when cfg_nine_i=1.
- cfg_nine_i, in, 1, 9 data bits.
- cfg_par_i, in, 2, parity: 0=none, 1=even, 2=odd, 3=none.
- cfg_stop2_i, in, 1, two stop bits.
- cfg_maxline_i, in, LINE_W, forced line-done length; 0 disables.
- data_o, out, 9, received character, LSB-aligned, upper bits zero.
- perr_o, out, 1, parity error for data_o.
- ferr_o, out, 1, framing error for data_o.
- valid_o, out, 1, FIFO not empty.
- ready_i, in, 1, consumer pop.
- overflow_o, out, 1, sticky: character dropped because FIFO was full.
- line_done_o, out, 1, one-cycle pulse.
- id_o, out, 8, ID.

Behaviour:

Reset (rst_i=1, synchronous):
- FSM goes to IDLE; FIFO is emptied.
- valid_o=0, data_o=0, perr_o=0, ferr_o=0, overflow_o=0, line_done_o=0.
- Line counter cleared; synchroniser loaded with 1s.

Input conditioning and configuration:
- rx_i passes through a 2-flop synchroniser; a falling edge is detected on the synchronised value (2-cycle input latency).
- Configuration is sampled on start-bit detection and held for the whole frame. Changes mid-frame do not affect the current frame.

Bit timer:
- Loaded with cfg_div_i−1 at each bit boundary.
- The mid-bit sample is taken when the timer equals cfg_div_i/2 (integer divide).

FSM:
- IDLE → START on falling edge while rx_en_i=1.
- START: mid-bit sample = 1 → glitch; return to IDLE with no FIFO push. Otherwise → DATA.
- DATA: shift in LSB first; after N bits → PARITY if parity enabled, else STOP.
- PARITY: compute XOR of data bits and received bit. Error if result = 1 (even) or result = 0 (odd).
- STOP: sample; 0 → ferr. With cfg_stop2_i=1 → STOP2 and sample again; ferr is the OR of both samples being 0.
- Last stop-bit mid-sample: push {data, perr, ferr}; return to IDLE immediately, so a new start edge can be accepted within half a bit.

FIFO and handshake:
- valid_o rises 1 cycle after the push.
- Pop occurs when valid_o & ready_i.
- Push and pop in the same cycle when full: both occur, no overflow.
- Push when full without a pop: the character is dropped and overflow_o is set until reset.

Line tracking:
- line_done_o pulses 1 cycle with the push of data 0x0A (ferr=0).
- Also pulses when the line counter reaches cfg_maxline_i−1 and cfg_maxline_i≠0.
- The counter clears on either pulse.

rx_en_i deassert:
- Any in-progress frame is aborted (no push); FSM goes to IDLE and the line counter clears.
- FIFO contents and popping are unaffected.
- A line held low when rx_en_i rises is not treated as a start; a falling edge is required.

Break condition:
- A frame that is all zero with ferr set is pushed as data 0 with ferr=1.
- The FSM re-arms only after rx returns high.

Decomposition:
- Package uart_vip_pkg:
  - parity_e enum {PAR_NONE, PAR_EVEN, PAR_ODD}.
  - rx_state_e enum {IDLE, START, DATA, PARITY, STOP, STOP2}.
  - rx_entry_t struct {logic [8:0] data; logic perr; logic ferr}.
  - LF constant 8'h0A.
- One sub-module: uart_vip_fifo, a synchronous FIFO of rx_entry_t with full/empty flags and parameter DEPTH.

Test Plan:
- cfg_div_i=16, 8N1; serialise 0x55 → exactly one pop with data_o=0x055, perr_o=0, ferr_o=0. valid_o rises 1 cycle after the stop-bit mid-sample.
- cfg_div_i=8, 7 bits, even parity; send 0x41 with a correct parity bit, then 0x41 with the parity bit flipped → perr_o=0, then perr_o=1.
- 8N2; send 0xA5 with the second stop bit driven 0 → data_o=0x0A5, ferr_o=1. Then 0x5A with correct stops → ferr_o=0.
- 4-cycle low glitch on rx_i with cfg_div_i=16 → no push, valid_o stays 0. Next valid frame 0x33 is received correctly.
- ready_i=0, FIFO_DEPTH=16; send 17 chars 0x00..0x10 → 16 entries 0x00..0x0F popped in order, overflow_o=1.
- Send "AB\n" → line_done_o pulses once, on the 0x0A push. Then cfg_maxline_i=3 and send "XYZW" → one pulse at 'Z'. Deassert rx_en_i mid-'W' → no push.

Source files
------------

// File: rtl/uart_vip_pkg.sv
// Shared types for the UART receive monitor: frame format, receiver states, FIFO entry.
package uart_vip_pkg;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} rx_state_e;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } rx_entry_t;

  localparam logic [7:0] LF = 8'h0A;

  // Encoding 3 is a reserved alias for "no parity".
  function automatic parity_e decode_par(input logic [1:0] p);
    case (p)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_vip_fifo.sv
// Synchronous FIFO of received characters; a push into a full FIFO is accepted only alongside a pop.
module uart_vip_fifo
  import uart_vip_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  rx_entry_t wdata,
  output rx_entry_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  rx_entry_t      mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [AW:0]    count;
  logic           do_push, do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/uart_vip_rx_mon.sv
// Clocked UART receive monitor: synchronised line, per-frame latched format, FIFO output, line-done strobe.
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | timing the start bit; high at mid-bit means glitch
// DATA   | shifting in data bits LSB first
// PARITY | checking the parity bit
// STOP   | first stop bit; pushes here unless two stop bits
// STOP2  | second stop bit; always pushes
module uart_vip_rx_mon
  import uart_vip_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int LINE_W     = 8,
  parameter int ID         = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_i,
  input  logic              rx_en_i,
  output logic              tx_o,
  input  logic              tx_en_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  input  logic [1:0]        cfg_bits_i,
  input  logic              cfg_nine_i,
  input  logic [1:0]        cfg_par_i,
  input  logic              cfg_stop2_i,
  input  logic [LINE_W-1:0] cfg_maxline_i,
  output logic [8:0]        data_o,
  output logic              perr_o,
  output logic              ferr_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              overflow_o,
  output logic              line_done_o,
  output logic [7:0]        id_o
);

  rx_state_e         state;
  logic              rx_s1, rx_s2, rx_prev;
  logic [DIV_W-1:0]  timer, div_r, half_r, div_eff;
  logic [3:0]        nbits_r, bit_cnt;
  parity_e           par_r;
  logic              stop2_r;
  logic [8:0]        shreg;
  logic              perr_r, ferr_r;
  logic [LINE_W-1:0] line_cnt;
  logic              fall, mid, push, pop, line_hit;
  logic              fifo_full, fifo_empty;
  rx_entry_t         push_entry, head;

  assign tx_o    = tx_en_i ? rx_i : 1'b1;
  assign id_o    = 8'(ID);
  assign div_eff = (cfg_div_i < DIV_W'(4)) ? DIV_W'(4) : cfg_div_i;
  assign fall    = rx_prev & ~rx_s2;
  assign mid     = (state != IDLE) && (timer == half_r);
  assign push    = rx_en_i && mid && ((state == STOP && !stop2_r) || state == STOP2);
  // ferr_r is clear unless a first stop bit was already sampled low.
  assign push_entry = '{data: shreg, perr: perr_r, ferr: ferr_r | ~rx_s2};
  assign line_hit = push &&
                    ((shreg == {1'b0, LF} && !push_entry.ferr) ||
                     (cfg_maxline_i != '0 && line_cnt == cfg_maxline_i - 1'b1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      state   <= IDLE;
      timer   <= '0;
      div_r   <= DIV_W'(4);
      half_r  <= DIV_W'(2);
      nbits_r <= 4'd8;
      bit_cnt <= '0;
      par_r   <= PAR_NONE;
      stop2_r <= 1'b0;
      shreg   <= '0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      rx_s1   <= rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (state != IDLE) timer <= (timer == '0) ? div_r - 1'b1 : timer - 1'b1;
      if (!rx_en_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (fall) begin
            state   <= START;
            timer   <= div_eff - 1'b1;
            div_r   <= div_eff;
            half_r  <= div_eff >> 1;
            nbits_r <= cfg_nine_i ? 4'd9 : 4'd5 + {2'b00, cfg_bits_i};
            par_r   <= decode_par(cfg_par_i);
            stop2_r <= cfg_stop2_i;
            shreg   <= '0;
            bit_cnt <= '0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
          end
          START: if (mid) state <= rx_s2 ? IDLE : DATA;
          DATA: if (mid) begin
            shreg[bit_cnt] <= rx_s2;
            bit_cnt        <= bit_cnt + 1'b1;
            if (bit_cnt == nbits_r - 4'd1) state <= (par_r == PAR_NONE) ? STOP : PARITY;
          end
          PARITY: if (mid) begin
            perr_r <= (^shreg) ^ rx_s2 ^ (par_r == PAR_ODD);
            state  <= STOP;
          end
          STOP: if (mid) begin
            ferr_r <= ~rx_s2;
            state  <= stop2_r ? STOP2 : IDLE;
          end
          STOP2: if (mid) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_o  <= 1'b0;
      line_done_o <= 1'b0;
      line_cnt    <= '0;
    end else begin
      line_done_o <= line_hit;
      if (push && fifo_full && !pop) overflow_o <= 1'b1;
      if (!rx_en_i || line_hit) line_cnt <= '0;
      else if (push)            line_cnt <= line_cnt + 1'b1;
    end
  end

  uart_vip_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign valid_o = ~fifo_empty;
  assign pop     = valid_o & ready_i;
  assign data_o  = valid_o ? head.data : 9'd0;
  assign perr_o  = valid_o & head.perr;
  assign ferr_o  = valid_o & head.ferr;

endmodule
